gtxe2_comm_qpll_refclk_ctrl: RTL and testbench

Sequencer for the QPLL reference-clock selection in the GTXE2 common block. It accepts a requested QPLLREFCLKSEL value, powers down and resets the QPLL around the mux switch, waits for the new clock to settle, and releases reset. It then supervises QPLLLOCK with a timeout and bounded retries. It sits between user/board logic and the QPLL input mux and QPLL control pins.

---
 rtl/gtxe2_comm_pkg.sv | 40 ++++
 rtl/gtxe2_comm_qpll_refclk_ctrl.sv | 123 ++++++++++++
 tb/tb_gtxe2_comm_qpll_refclk_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/gtxe2_comm_pkg.sv
// rtl/gtxe2_comm_pkg.sv - shared types and constants for the GTXE2 common-block QPLL refclk control
package gtxe2_comm_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    SETTLE    = 3'd1,
    GAP       = 3'd2,
    WAIT_LOCK = 3'd3,
    LOCKED    = 3'd4,
    FAIL      = 3'd5
  } qpll_state_t;

  localparam logic [2:0] QPLLREFCLKSEL_RESERVED = 3'b000;
  localparam logic [2:0] SEL_GTREFCLK0          = 3'b001;
  localparam logic [2:0] SEL_GTREFCLK1          = 3'b010;
  localparam logic [2:0] SEL_GTNORTHREFCLK0     = 3'b011;
  localparam logic [2:0] SEL_GTNORTHREFCLK1     = 3'b100;
  localparam logic [2:0] SEL_GTSOUTHREFCLK0     = 3'b101;
  localparam logic [2:0] SEL_GTSOUTHREFCLK1     = 3'b110;
  localparam logic [2:0] SEL_GTGREFCLK          = 3'b111;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // QPLL is powered down whenever the mux may be moving or the sequence has given up
  function automatic logic state_pd(input qpll_state_t s);
    return (s == HOLD) || (s == SETTLE) || (s == FAIL);
  endfunction

  function automatic logic state_rst(input qpll_state_t s);
    return (s != WAIT_LOCK) && (s != LOCKED);
  endfunction

endpackage

// File: rtl/gtxe2_comm_qpll_refclk_ctrl.sv
// rtl/gtxe2_comm_qpll_refclk_ctrl.sv - QPLL refclk select sequencer with lock supervision and retries
module gtxe2_comm_qpll_refclk_ctrl
  import gtxe2_comm_pkg::*;
#(
  parameter logic [2:0] DEFAULT_SEL   = 3'b001,
  parameter int         HOLD_CYCLES   = 8,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         PD_RESET_GAP  = 4,
  parameter int         LOCK_TIMEOUT  = 1024,
  parameter int         MAX_RETRIES   = 3
) (
  input  logic       QPLLLOCKDETCLK,
  input  logic       RESET,
  input  logic [2:0] SEL_REQ,
  input  logic       SEL_REQ_VALID,
  output logic       SEL_REQ_READY,
  input  logic       QPLLLOCK,
  output logic [2:0] QPLLREFCLKSEL,
  output logic       QPLLPD,
  output logic       QPLLRESET,
  output logic       SEL_DONE,
  output logic       SEL_ERROR,
  output logic       FAILED,
  output logic       BUSY,
  output logic [2:0] RETRY_CNT
);

  localparam int CW = $clog2(max4(HOLD_CYCLES, SETTLE_CYCLES, PD_RESET_GAP, LOCK_TIMEOUT)) + 1;

  qpll_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    pend_sel;

  logic req_accept, req_reserved, req_go;
  logic load_sel, retry_inc, retry_clr, lock_done, lock_fail;

  assign SEL_REQ_READY = (state == LOCKED) || (state == FAIL);
  assign BUSY          = !SEL_REQ_READY;

  assign req_accept   = SEL_REQ_VALID && SEL_REQ_READY;
  assign req_reserved = req_accept && (SEL_REQ == QPLLREFCLKSEL_RESERVED);
  assign req_go       = req_accept && (SEL_REQ != QPLLREFCLKSEL_RESERVED);

  always_ff @(posedge QPLLLOCKDETCLK) begin
    if (RESET) state <= HOLD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_sel   = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    lock_done  = 1'b0;
    lock_fail  = 1'b0;
    case (state)
      HOLD: if (cnt == CW'(HOLD_CYCLES - 1)) begin
        state_next = SETTLE;
        load_sel   = 1'b1;
      end
      SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) state_next = GAP;
      GAP:    if (cnt == CW'(PD_RESET_GAP - 1))  state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        // lock wins over a coincident timeout
        if (QPLLLOCK) begin
          state_next = LOCKED;
          lock_done  = 1'b1;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          if (RETRY_CNT < 3'(MAX_RETRIES)) begin
            state_next = GAP;
            retry_inc  = 1'b1;
          end else begin
            state_next = FAIL;
            lock_fail  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (req_go) begin
          state_next = HOLD;
          retry_clr  = 1'b1;
        end else if (!req_reserved && !QPLLLOCK) begin
          state_next = GAP;
          retry_clr  = 1'b1;
        end
      end
      FAIL: if (req_go) begin
        state_next = HOLD;
        retry_clr  = 1'b1;
      end
      default: state_next = HOLD;
    endcase
  end

  // QPLL pins are registered from the next state so they never glitch on state decode
  always_ff @(posedge QPLLLOCKDETCLK) begin
    if (RESET) begin
      cnt           <= '0;
      pend_sel      <= DEFAULT_SEL;
      QPLLREFCLKSEL <= DEFAULT_SEL;
      QPLLPD        <= 1'b1;
      QPLLRESET     <= 1'b1;
      SEL_DONE      <= 1'b0;
      SEL_ERROR     <= 1'b0;
      FAILED        <= 1'b0;
      RETRY_CNT     <= 3'd0;
    end else begin
      if (state_next != state || state == LOCKED || state == FAIL) cnt <= '0;
      else                                                         cnt <= cnt + CW'(1);
      if (req_go)   pend_sel      <= SEL_REQ;
      if (load_sel) QPLLREFCLKSEL <= pend_sel;
      QPLLPD    <= state_pd(state_next);
      QPLLRESET <= state_rst(state_next);
      SEL_DONE  <= lock_done;
      SEL_ERROR <= req_reserved || lock_fail;
      if (req_go)         FAILED <= 1'b0;
      else if (lock_fail) FAILED <= 1'b1;
      if (retry_clr)      RETRY_CNT <= 3'd0;
      else if (retry_inc) RETRY_CNT <= RETRY_CNT + 3'd1;
    end
  end

endmodule

// File: tb/tb_gtxe2_comm_qpll_refclk_ctrl.sv
// tb/tb_gtxe2_comm_qpll_refclk_ctrl.sv - directed table-driven bench for the QPLL refclk sequencer
module tb_gtxe2_comm_qpll_refclk_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [2:0] sel_req;
  logic       sel_vld;
  logic       lock;
  logic       ready, pd, qrst, done, err, failed, busy;
  logic [2:0] sel, retry;

  always #5 clk = ~clk;

  gtxe2_comm_qpll_refclk_ctrl #(
    .DEFAULT_SEL  (3'b001),
    .HOLD_CYCLES  (8),
    .SETTLE_CYCLES(16),
    .PD_RESET_GAP (4),
    .LOCK_TIMEOUT (64),
    .MAX_RETRIES  (3)
  ) dut (
    .QPLLLOCKDETCLK(clk),
    .RESET         (rst_i),
    .SEL_REQ       (sel_req),
    .SEL_REQ_VALID (sel_vld),
    .SEL_REQ_READY (ready),
    .QPLLLOCK      (lock),
    .QPLLREFCLKSEL (sel),
    .QPLLPD        (pd),
    .QPLLRESET     (qrst),
    .SEL_DONE      (done),
    .SEL_ERROR     (err),
    .FAILED        (failed),
    .BUSY          (busy),
    .RETRY_CNT     (retry)
  );

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       vld;
    logic       lock;
    int         n;
    logic [2:0] e_sel;
    logic       e_pd, e_rst, e_busy, e_rdy, e_failed;
    logic [2:0] e_retry;
    int         e_done, e_err;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad   = 0;
  int done_seen, err_seen;
  logic [2:0] sel_prev;
  logic       pd_prev;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock; sampled on the falling edge, also watches the select while the QPLL is powered
  task automatic step();
    @(negedge clk);
    if (done) done_seen++;
    if (err)  err_seen++;
    if (!pd_prev && !pd) chk("sel_stable_while_powered", int'(sel), int'(sel_prev));
    sel_prev = sel;
    pd_prev  = pd;
  endtask

  task automatic add(input logic r, input logic [2:0] q, input logic v, input logic l, input int n,
                     input logic [2:0] es, input logic ep, input logic er, input logic eb,
                     input logic ey, input logic ef, input logic [2:0] et, input int ed, input int ee);
    vec_t x;
    x.rst = r; x.req = q; x.vld = v; x.lock = l; x.n = n;
    x.e_sel = es; x.e_pd = ep; x.e_rst = er; x.e_busy = eb; x.e_rdy = ey;
    x.e_failed = ef; x.e_retry = et; x.e_done = ed; x.e_err = ee;
    tv.push_back(x);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] es, input logic ep, input logic er,
                           input logic eb, input logic ey, input logic ef, input logic [2:0] et);
    chk({tag, ".sel"},    int'(sel),    int'(es));
    chk({tag, ".pd"},     int'(pd),     int'(ep));
    chk({tag, ".rst"},    int'(qrst),   int'(er));
    chk({tag, ".busy"},   int'(busy),   int'(eb));
    chk({tag, ".ready"},  int'(ready),  int'(ey));
    chk({tag, ".failed"}, int'(failed), int'(ef));
    chk({tag, ".retry"},  int'(retry),  int'(et));
  endtask

  initial begin
    int c, rises;
    logic rst_prev;
    bit found;
    rst_i = 1'b1; sel_req = 3'd0; sel_vld = 1'b0; lock = 1'b0;
    sel_prev = 3'b001; pd_prev = 1'b1;

    //   rst req vld lk  n   sel pd rs by ry fl rt dn er
    add(1, 0, 0, 0,  2,  1, 1, 1, 1, 0, 0, 0, 0, 0);  // reset values
    add(0, 0, 0, 0,  7,  1, 1, 1, 1, 0, 0, 0, 0, 0);  // HOLD
    add(0, 0, 0, 0,  1,  1, 1, 1, 1, 0, 0, 0, 0, 0);  // SETTLE entered
    add(0, 0, 0, 0, 15,  1, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1,  1, 0, 1, 1, 0, 0, 0, 0, 0);  // PD falls at 24
    add(0, 0, 0, 0,  3,  1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1,  1, 0, 0, 1, 0, 0, 0, 0, 0);  // QPLLRESET falls at 28
    add(0, 0, 0, 0, 49,  1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  1,  1, 0, 0, 0, 1, 0, 0, 1, 0);  // lock 50 cycles later
    add(0, 0, 0, 1,  3,  1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1,  1,  1, 0, 0, 0, 1, 0, 0, 0, 1);  // reserved request
    add(0, 0, 0, 1,  2,  1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 5, 1, 0,  1,  1, 1, 1, 1, 0, 0, 0, 0, 0);  // switch wins over lock loss
    add(0, 5, 0, 0,  7,  1, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0,  1,  5, 1, 1, 1, 0, 0, 0, 0, 0);  // select moves after 8 HOLD cycles
    add(0, 5, 0, 0, 15,  5, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0,  1,  5, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0,  3,  5, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0,  1,  5, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  1,  5, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0,  1,  5, 0, 1, 1, 0, 0, 0, 0, 0);  // lock loss -> GAP
    add(0, 0, 0, 1,  3,  5, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  1,  5, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  1,  5, 0, 0, 0, 1, 0, 0, 1, 0);

    foreach (tv[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      rst_i = tv[i].rst; sel_req = tv[i].req; sel_vld = tv[i].vld; lock = tv[i].lock;
      done_seen = 0; err_seen = 0;
      repeat (tv[i].n) step();
      chk_state(tag, tv[i].e_sel, tv[i].e_pd, tv[i].e_rst, tv[i].e_busy, tv[i].e_rdy,
                tv[i].e_failed, tv[i].e_retry);
      chk({tag, ".done_pulses"}, done_seen, tv[i].e_done);
      chk({tag, ".err_pulses"},  err_seen,  tv[i].e_err);
    end

    // timeout with three retries, then FAIL
    sel_req = 3'b011; sel_vld = 1'b1; lock = 1'b0;
    step();
    sel_vld = 1'b0;
    err_seen = 0; rises = 0; rst_prev = qrst; c = 1;
    while (!failed && c < 1000) begin
      step();
      c++;
      if (!rst_prev && qrst && !failed) begin
        rises++;
        chk("retry_cnt_on_rerst", int'(retry), rises);
        chk("pd_low_on_retry", int'(pd), 0);
      end
      rst_prev = qrst;
    end
    chk("fail_cycle", c, 297);
    chk("retry_rises", rises, 3);
    chk("fail_err_pulses", err_seen, 1);
    chk_state("fail", 3'b011, 1, 1, 0, 1, 1, 3);

    sel_req = 3'b000; sel_vld = 1'b1;
    step();
    sel_vld = 1'b0;
    chk("fail_reserved_err", int'(err), 1);
    chk_state("fail_reserved", 3'b011, 1, 1, 0, 1, 1, 3);

    sel_req = 3'b010; sel_vld = 1'b1;
    step();
    sel_vld = 1'b0;
    chk_state("restart", 3'b011, 1, 1, 1, 0, 0, 0);
    found = 1'b0;
    for (int k = 2; k <= 100 && !found; k++) begin
      step();
      if (!qrst) begin
        found = 1'b1;
        chk("restart_rst_fall_cycle", k, 29);
      end
    end
    chk("restart_rst_fell", int'(found), 1);
    lock = 1'b1; done_seen = 0;
    step();
    chk("restart_done", done_seen, 1);
    chk_state("restart_locked", 3'b010, 0, 0, 0, 1, 0, 0);

    // reset during SETTLE of a switch to 110
    sel_req = 3'b110; sel_vld = 1'b1; lock = 1'b0;
    step();
    sel_vld = 1'b0;
    repeat (13) step();
    chk_state("mid_settle", 3'b110, 1, 1, 1, 0, 0, 0);
    rst_i = 1'b1; done_seen = 0; err_seen = 0;
    step();
    chk_state("mid_reset", 3'b001, 1, 1, 1, 0, 0, 0);
    chk("mid_reset_done", int'(done), 0);
    chk("mid_reset_err", int'(err), 0);
    rst_i = 1'b0;
    repeat (8) step();
    chk_state("mid_rehold", 3'b001, 1, 1, 1, 0, 0, 0);
    repeat (16) step();
    chk_state("mid_regap", 3'b001, 0, 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
